// File: rtl/xor_descrambler.sv
// xor_descrambler: additive stream descrambler, 16-bit words XORed with a
// Galois-LFSR keystream that advances 16 steps per accepted word.
//
// Ports:
//   clk, rst             rising-edge clock, synchronous active-high reset
//   seed_load, seed      resync pulse and value (seed 0 maps to 16'h0001)
//   in_valid, in_data    scrambled word from upstream
//   in_ready             word accepted this cycle when in_valid is high
//   out_valid, out_data  plain word to downstream, held until out_ready
//   out_ready            downstream takes out_data this cycle
//   synced               high once a seed has been loaded
//   word_count           words accepted since the last seed_load or reset
//
// Build option: define XNOR_KEY_EN for the XNOR-scrambled link variant,
// where out_data is the inverted XOR of word and keystream.

module xor_descrambler #(
    parameter logic [15:0] POLY     = 16'hB400,
    parameter logic [15:0] SEED_RST = 16'hACE1,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             seed_load,
    input  logic [15:0]      seed,
    input  logic             in_valid,
    input  logic [15:0]      in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [15:0]      out_data,
    input  logic             out_ready,
    output logic             synced,
    output logic [CNT_W-1:0] word_count
);

    typedef enum logic {
        UNSEEDED = 1'b0,
        RUN      = 1'b1
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [15:0]     lfsr_q;
    logic [15:0]     lfsr_adv;
    logic [15:0]     seed_eff;
    logic [15:0]     plain;
    logic            accept;

    // One Galois step in right-shift form.
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        logic [15:0] r;
        r = s >> 1;
        if (s[0]) begin
            r = r ^ POLY;
        end
        return r;
    endfunction

    // Sixteen steps unrolled, one per keystream bit consumed by a word.
    function automatic logic [15:0] lfsr_step16(input logic [15:0] s);
        logic [15:0] r;
        r = s;
        for (int i = 0; i < 16; i++) begin
            r = lfsr_step(r);
        end
        return r;
    endfunction

    // FSM next-state: seed_load is the only way into, and within, RUN.
    always_comb begin
        state_d = state_q;
        if (seed_load) begin
            state_d = RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= UNSEEDED;
        end else begin
            state_q <= state_d;
        end
    end

    // A pending output may be replaced in the same cycle it is taken.
    always_comb begin
        in_ready = (state_q == RUN) && !seed_load &&
                   (!out_valid || out_ready);
    end

    assign accept   = in_valid && in_ready;
    assign synced   = (state_q == RUN);
    assign lfsr_adv = lfsr_step16(lfsr_q);

    // An all-zero LFSR would never leave zero, so remap it.
    assign seed_eff = (seed == 16'h0000) ? 16'h0001 : seed;

`ifdef XNOR_KEY_EN
    assign plain = ~(in_data ^ lfsr_q);
`else
    assign plain = in_data ^ lfsr_q;
`endif

    // Keystream state and word counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q     <= SEED_RST;
            word_count <= '0;
        end else if (seed_load) begin
            lfsr_q     <= seed_eff;
            word_count <= '0;
        end else if (accept) begin
            lfsr_q     <= lfsr_adv;
            word_count <= word_count + 1'b1;
        end
    end

    // Output register: a pending word survives seed_load untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= 16'h0000;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= plain;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
